// File: rtl/pattern_detect_param_if.sv
// ---------------------------------------------------------------------------
// pattern_detect_param_if
// Bundles the serial stream, control and status signals of
// pattern_detect_param.
//   master : drives en, x, ovl, pat_ld, pat_in, clr_cnt; observes y, count, sat
//   slave  : the detector itself
// Parameters W and CNT_W must match the detector instance.
// ---------------------------------------------------------------------------
interface pattern_detect_param_if #(
    parameter int W     = 5,
    parameter int CNT_W = 8
);
    logic             en;       // sample qualifier
    logic             x;        // serial data bit
    logic             ovl;      // 1 = overlapping matches allowed
    logic             pat_ld;   // load pat_in into the pattern register
    logic [W-1:0]     pat_in;   // new pattern, MSB oldest
    logic             clr_cnt;  // clear match counter and saturation flag
    logic             y;        // registered one-cycle match pulse
    logic [CNT_W-1:0] count;    // saturating match count
    logic             sat;      // sticky: counter reached all-ones

    modport master (
        output en, x, ovl, pat_ld, pat_in, clr_cnt,
        input  y, count, sat
    );

    modport slave (
        input  en, x, ovl, pat_ld, pat_in, clr_cnt,
        output y, count, sat
    );
endinterface

// File: rtl/pattern_detect_param.sv
// ---------------------------------------------------------------------------
// pattern_detect_param
// Serial detector for a W-bit pattern on a 1-bit stream. The pattern resets
// to PATTERN and can be reloaded at runtime; overlapping or non-overlapping
// matching is selected per sample. Each match gives a registered one-cycle
// pulse on y and bumps a saturating counter with a sticky saturation flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : pattern_detect_param_if.slave (en, x, ovl, pat_ld, pat_in,
//          clr_cnt in; y, count, sat out)
// ---------------------------------------------------------------------------
module pattern_detect_param #(
    parameter int             W       = 5,
    parameter logic [W-1:0]   PATTERN = 5'b10101,
    parameter int             CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pattern_detect_param_if.slave  bus
);
    // Fill counter only needs to reach W-1.
    localparam int               FW       = (W > 2) ? $clog2(W) : 1;
    localparam logic [FW-1:0]    FILL_MAX = FW'(W - 1);
    localparam logic [FW-1:0]    FILL_ONE = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [W-1:0]     pat_q,   pat_d;
    logic [W-2:0]     hist_q,  hist_d;
    logic [FW-1:0]    fill_q,  fill_d;
    logic             y_q,     y_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q,   sat_d;

    logic [W-1:0]     cand;
    logic             match;

    // Window formed by the stored history plus the bit on the line now.
    assign cand = {hist_q, bus.x};

    // NOTE: next-state logic uses blocking '=' in always_comb with every
    // output defaulted first (no latches); the registers below use '<=' only.
    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match   = 1'b0;

        if (bus.pat_ld) begin
            // A load flushes history, so the sample on this cycle is dropped.
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            match  = (fill_q == FILL_MAX) && (cand == pat_q);
            hist_d = cand[W-2:0];
            if (match) begin
                // Overlap keeps the window full so the match suffix can seed
                // the next one; non-overlap demands W fresh samples.
                fill_d = bus.ovl ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_ONE;
            end
        end

        y_d = match;

        // Clear first, then count, so clr_cnt on a matching cycle leaves 1.
        count_d = bus.clr_cnt ? '0 : count_q;
        if (match && (count_d != CNT_MAX)) begin
            count_d = count_d + CNT_ONE;
        end
        sat_d = (bus.clr_cnt ? 1'b0 : sat_q) | (count_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.count = count_q;
    assign bus.sat   = sat_q;
endmodule
